// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and op-class helpers.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADC  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SBC  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOT  = 4'd7;
  localparam logic [3:0] ALU_SHL  = 4'd8;
  localparam logic [3:0] ALU_SHR  = 4'd9;
  localparam logic [3:0] ALU_ASR  = 4'd10;
  localparam logic [3:0] ALU_ROL  = 4'd11;
  localparam logic [3:0] ALU_MULL = 4'd12;
  localparam logic [3:0] ALU_MULH = 4'd13;
  localparam logic [3:0] ALU_CMP  = 4'd14;
  localparam logic [3:0] ALU_PASS = 4'd15;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SHL) || (op == ALU_SHR) || (op == ALU_ASR) || (op == ALU_ROL);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == ALU_MULL) || (op == ALU_MULH);
  endfunction

  // Op class that may occupy the ALU for more than one cycle (a zero-count
  // shift still finishes in one cycle).
  function automatic logic is_multicycle(input logic [3:0] op);
    return is_shift(op) || is_mul(op);
  endfunction

endpackage

// File: rtl/alu_mul.sv
// Iterative unsigned shift-add multiplier. The first step is taken on the
// start edge; done is asserted during the cycle whose step is the last one,
// with prod already showing that final step's result.
module alu_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int CNTW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [CNTW-1:0]    cnt;
  logic               busy;

  // One shift-add step: conditionally add the multiplicand to the upper half,
  // then shift the whole accumulator right, consuming one multiplier bit.
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                              input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] s;
    s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {s, p[WIDTH-1:1]};
  endfunction

  // Accumulator, multiplicand and remaining-step down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      acc   <= step({{WIDTH{1'b0}}, b}, a);
      mcand <= a;
      cnt   <= CNTW'(WIDTH - 1);
      busy  <= 1'b1;
    end else if (busy) begin
      acc <= step(acc, mcand);
      cnt <= cnt - CNTW'(1);
      if (done) busy <= 1'b0;
    end
  end

  assign done = busy && (cnt == CNTW'(1));
  assign prod = step(acc, mcand);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered result and Z/N/C/V flag register.
//   state  | meaning
//   S_IDLE | ready for operands; single-cycle ops complete from here
//   S_BUSY | iterating a shift (one bit per cycle) or a multiply
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  state_t             state, state_d;
  logic [3:0]         op_r, op_d;
  logic [WIDTH-1:0]   sh, sh_d;
  logic [CW-1:0]      rem, rem_d;
  logic [WIDTH-1:0]   out_d;
  logic               ov_d, z_d, n_d, c_d, v_d;
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;
  logic               cin;
  logic [WIDTH:0]     sum, dif, stp;
  logic [WIDTH-1:0]   res;
  logic               wr;

  // Returns {bit shifted/rotated out, new value} for one bit-step.
  function automatic logic [WIDTH:0] shift_step(input logic [3:0] sop,
                                                 input logic [WIDTH-1:0] x);
    case (sop)
      ALU_SHL: return {x[M], x[M-1:0], 1'b0};
      ALU_SHR: return {x[0], 1'b0, x[M:1]};
      ALU_ASR: return {x[0], x[M], x[M:1]};
      default: return {x[M], x[M-1:0], x[M]};
    endcase
  endfunction

  alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (prod)
  );

  assign in_ready = (state == S_IDLE);
  assign cout     = c;
  assign cnt      = b[CW-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state, result and flag computation.
  always_comb begin
    state_d   = state;
    op_d      = op_r;
    sh_d      = sh;
    rem_d     = rem;
    out_d     = out;
    z_d       = z;
    n_d       = n;
    c_d       = c;
    v_d       = v;
    ov_d      = 1'b0;
    mul_start = 1'b0;
    wr        = 1'b0;
    res       = '0;
    stp       = '0;
    cin       = ((op == ALU_ADC) || (op == ALU_SBC)) ? c : 1'b0;
    sum       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    dif       = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          op_d = op;
          if (is_mul(op)) begin
            mul_start = 1'b1;
            state_d   = S_BUSY;
          end else if (is_shift(op)) begin
            if (cnt == '0) begin
              wr  = 1'b1;
              res = a;
              v_d = 1'b0;
            end else begin
              stp   = shift_step(op, a);
              sh_d  = stp[M:0];
              rem_d = cnt - CW'(1);
              if (cnt == CW'(1)) begin
                wr  = 1'b1;
                res = stp[M:0];
                c_d = stp[WIDTH];
                v_d = 1'b0;
              end else begin
                state_d = S_BUSY;
              end
            end
          end else begin
            wr  = 1'b1;
            v_d = 1'b0;
            case (op)
              ALU_ADD, ALU_ADC: begin
                res = sum[M:0];
                c_d = sum[WIDTH];
                v_d = (a[M] == b[M]) && (sum[M] != a[M]);
              end
              ALU_SUB, ALU_SBC: begin
                res = dif[M:0];
                c_d = dif[WIDTH];
                v_d = (a[M] != b[M]) && (dif[M] != a[M]);
              end
              ALU_AND: res = a & b;
              ALU_OR:  res = a | b;
              ALU_XOR: res = a ^ b;
              ALU_NOT: res = ~a;
              ALU_CMP: begin
                wr   = 1'b0;
                ov_d = 1'b1;
                z_d  = ~|dif[M:0];
                n_d  = dif[M];
                c_d  = dif[WIDTH];
                v_d  = (a[M] != b[M]) && (dif[M] != a[M]);
              end
              default: res = b;
            endcase
          end
        end
      end
      S_BUSY: begin
        if (is_shift(op_r)) begin
          stp   = shift_step(op_r, sh);
          sh_d  = stp[M:0];
          rem_d = rem - CW'(1);
          if (rem == CW'(1)) begin
            wr      = 1'b1;
            res     = stp[M:0];
            c_d     = stp[WIDTH];
            v_d     = 1'b0;
            state_d = S_IDLE;
          end
        end else if (mul_done) begin
          wr      = 1'b1;
          v_d     = 1'b0;
          state_d = S_IDLE;
          if (op_r == ALU_MULL) begin
            res = prod[M:0];
            c_d = |prod[2*WIDTH-1:WIDTH];
          end else begin
            res = prod[2*WIDTH-1:WIDTH];
            c_d = |prod[M:0];
          end
        end
      end
    endcase
    if (wr) begin
      out_d = res;
      z_d   = ~|res;
      n_d   = res[M];
      ov_d  = 1'b1;
    end
  end

  // Result, flag and shift-working registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      z         <= 1'b0;
      n         <= 1'b0;
      c         <= 1'b0;
      v         <= 1'b0;
      sh        <= '0;
      rem       <= '0;
      op_r      <= '0;
    end else begin
      out       <= out_d;
      out_valid <= ov_d;
      z         <= z_d;
      n         <= n_d;
      c         <= c_d;
      v         <= v_d;
      sh        <= sh_d;
      rem       <= rem_d;
      op_r      <= op_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed and reference-model checks for alu_mc at WIDTH=8.
module tb_alu_mc;

  localparam logic [3:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2, OP_SBC = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd8, OP_SHR = 4'd9, OP_ASR = 4'd10, OP_ROL = 4'd11;
  localparam logic [3:0] OP_MULL = 4'd12, OP_MULH = 4'd13, OP_CMP = 4'd14, OP_PASS = 4'd15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0, b = '0;
  logic [3:0] op = '0;
  logic [7:0] out;
  logic       out_valid, z, n, c, v, cout;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mc #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out(out), .out_valid(out_valid),
    .z(z), .n(n), .c(c), .v(v), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
  endtask

  // Called in the acceptance cycle; returns the cycle offset of out_valid.
  task automatic wait_out(output int lat);
    lat = 1;
    tick();
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic ref_model(input logic [3:0] mop, input logic [7:0] ma, input logic [7:0] mb,
                           inout logic [7:0] mo, inout logic mz, inout logic mn,
                           inout logic mc, inout logic mv, output int mlat);
    int ua, ub, sa, sb, r, sr, ci, k;
    logic [15:0] p;
    logic [7:0] res;
    logic wr;
    ua = int'(ma); ub = int'(mb);
    sa = int'($signed(ma)); sb = int'($signed(mb));
    ci = (mop == OP_ADC || mop == OP_SBC) ? int'(mc) : 0;
    k = int'(mb[2:0]);
    mlat = 1; wr = 1'b1; res = 8'h00;
    case (mop)
      OP_ADD, OP_ADC: begin
        r = ua + ub + ci; sr = sa + sb + ci;
        res = r[7:0]; mc = (r > 255); mv = (sr > 127) || (sr < -128);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        r = ua - ub - ci; sr = sa - sb - ci;
        res = r[7:0]; mc = (r < 0); mv = (sr > 127) || (sr < -128);
        if (mop == OP_CMP) begin
          wr = 1'b0; mz = (res == 8'h00); mn = res[7];
        end
      end
      4'd4: begin res = ma & mb; mv = 1'b0; end
      4'd5: begin res = ma | mb; mv = 1'b0; end
      4'd6: begin res = ma ^ mb; mv = 1'b0; end
      4'd7: begin res = ~ma; mv = 1'b0; end
      OP_SHL, OP_SHR, OP_ASR, OP_ROL: begin
        mv = 1'b0;
        if (k == 0) res = ma;
        else begin
          mlat = k;
          case (mop)
            OP_SHL: begin res = ma << k; mc = ma[8-k]; end
            OP_SHR: begin res = ma >> k; mc = ma[k-1]; end
            OP_ASR: begin res = $signed(ma) >>> k; mc = ma[k-1]; end
            default: begin res = (ma << k) | (ma >> (8 - k)); mc = res[0]; end
          endcase
        end
      end
      OP_MULL, OP_MULH: begin
        p = 16'(ma) * 16'(mb); mlat = 8; mv = 1'b0;
        if (mop == OP_MULL) begin res = p[7:0]; mc = |p[15:8]; end
        else begin res = p[15:8]; mc = |p[7:0]; end
      end
      default: begin res = mb; mv = 1'b0; end
    endcase
    if (wr) begin
      mo = res; mz = (res == 8'h00); mn = res[7];
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_checks++; if (out !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h want 00", out); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if ({z, n, c, v} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {z, n, c, v}); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add_adc;
    int lat;
    drive(OP_ADD, 8'hFF, 8'h01);
    wait_out(lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", lat); end
    n_checks++; if (out !== 8'h00) begin n_fail++; $display("FAIL add_out: got %h want 00", out); end
    n_checks++; if ({z, n, c, v} !== 4'b1010) begin n_fail++; $display("FAIL add_flags: got %b want 1010", {z, n, c, v}); end
    n_checks++; if (cout !== 1'b1) begin n_fail++; $display("FAIL add_cout: got %b want 1", cout); end
    drive(OP_ADC, 8'h10, 8'h20);
    wait_out(lat);
    n_checks++; if (out !== 8'h31) begin n_fail++; $display("FAIL adc_out: got %h want 31", out); end
    n_checks++; if ({z, n, c, v} !== 4'b0000) begin n_fail++; $display("FAIL adc_flags: got %b want 0000", {z, n, c, v}); end
  endtask

  task automatic test_sub_cmp;
    int lat;
    drive(OP_SUB, 8'h80, 8'h01);
    wait_out(lat);
    n_checks++; if (out !== 8'h7F) begin n_fail++; $display("FAIL sub_out: got %h want 7f", out); end
    n_checks++; if ({z, n, c, v} !== 4'b0001) begin n_fail++; $display("FAIL sub_flags: got %b want 0001", {z, n, c, v}); end
    drive(OP_CMP, 8'h05, 8'h07);
    wait_out(lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL cmp_latency: got %0d want 1", lat); end
    n_checks++; if (out !== 8'h7F) begin n_fail++; $display("FAIL cmp_out_held: got %h want 7f", out); end
    n_checks++; if ({z, n, c, v} !== 4'b0110) begin n_fail++; $display("FAIL cmp_flags: got %b want 0110", {z, n, c, v}); end
  endtask

  task automatic test_shift;
    int lat;
    drive(OP_SHL, 8'h81, 8'h03);
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL shl_ready_k1: got %b want 0", in_ready); end
    drive(OP_PASS, 8'h00, 8'hAA);
    tick();
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL shl_busy_k2: ready %b valid %b want 0 0", in_ready, out_valid); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL shl_done_k3: valid %b ready %b want 1 1", out_valid, in_ready); end
    n_checks++; if (out !== 8'h08 || c !== 1'b0) begin n_fail++; $display("FAIL shl_result: out %h c %b want 08 0", out, c); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || out !== 8'h08) begin n_fail++; $display("FAIL busy_in_valid_ignored: valid %b out %h want 0 08", out_valid, out); end
    drive(OP_CMP, 8'h01, 8'h02);
    wait_out(lat);
    drive(OP_SHR, 8'h5A, 8'h00);
    wait_out(lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL shr0_latency: got %0d want 1", lat); end
    n_checks++; if (out !== 8'h5A || {z, n, c, v} !== 4'b0010) begin n_fail++; $display("FAIL shr0_result: out %h flags %b want 5a 0010", out, {z, n, c, v}); end
  endtask

  task automatic test_mul;
    int lat;
    drive(OP_MULL, 8'h0F, 8'h11);
    wait_out(lat);
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL mull_latency: got %0d want 8", lat); end
    n_checks++; if (out !== 8'hFF || {z, n, c, v} !== 4'b0100) begin n_fail++; $display("FAIL mull_result: out %h flags %b want ff 0100", out, {z, n, c, v}); end
    drive(OP_MULH, 8'hFF, 8'hFF);
    wait_out(lat);
    n_checks++; if (out !== 8'hFE || {z, n, c, v} !== 4'b0110) begin n_fail++; $display("FAIL mulh_result: out %h flags %b want fe 0110", out, {z, n, c, v}); end
  endtask

  task automatic test_rst_mid;
    int lat, seen;
    drive(OP_MULL, 8'h03, 8'h05);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (out !== 8'h00 || {z, n, c, v} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_clear: out %h flags %b want 00 0000", out, {z, n, c, v}); end
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: ready %b valid %b want 1 0", in_ready, out_valid); end
    seen = 0;
    repeat (10) begin
      tick();
      if (out_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_valid: got %0d pulses want 0", seen); end
    drive(OP_ADD, 8'h03, 8'h04);
    wait_out(lat);
    n_checks++; if (lat !== 1 || out !== 8'h07) begin n_fail++; $display("FAIL add_after_rst: lat %0d out %h want 1 07", lat, out); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] ops [20];
    logic [7:0] as [20];
    logic [7:0] bs [20];
    logic [7:0] eo;
    logic ez, en, ec, ev;
    int lat, elat, seen;
    for (int i = 0; i < 20; i++) begin
      ops[i] = (i < 16) ? 4'((i * 7) % 16) : 4'($urandom_range(0, 15));
      as[i]  = 8'($urandom);
      bs[i]  = 8'($urandom);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    eo = 8'h00; ez = 1'b0; en = 1'b0; ec = 1'b0; ev = 1'b0;
    drive(ops[0], as[0], bs[0]);
    for (int i = 0; i < 20; i++) begin
      ref_model(ops[i], as[i], bs[i], eo, ez, en, ec, ev, elat);
      wait_out(lat);
      n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL b2b_latency[%0d] op %0d: got %0d want %0d", i, ops[i], lat, elat); end
      n_checks++; if (out !== eo) begin n_fail++; $display("FAIL b2b_out[%0d] op %0d a %h b %h: got %h want %h", i, ops[i], as[i], bs[i], out, eo); end
      n_checks++; if ({z, n, c, v} !== {ez, en, ec, ev}) begin n_fail++; $display("FAIL b2b_flags[%0d] op %0d: got %b want %b", i, ops[i], {z, n, c, v}, {ez, en, ec, ev}); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
      if (i < 19) drive(ops[i+1], as[i+1], bs[i+1]);
    end
    seen = 0;
    repeat (10) begin
      tick();
      if (out_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL b2b_extra_valid: got %0d pulses want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_add_adc();
    test_sub_cmp();
    test_shift();
    test_mul();
    test_rst_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
